mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and sequencer that shares the single-ported, combinationally accessed `memory_block` between the instruction-fetch path and the data (load/store) path. It accepts one request per port via a req/ack handshake and latches the winning request. It drives the memory control signals only from registers, so `memWrite` never glitches. It returns read data in a registered per-port buffer. It sits between the core pipeline and `memory_block`.

## Interface
- `ADDR_W`, 18, word address width (matches `memory_block.address`)
- `DATA_W`, 32, data width

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request (word read only); held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_ack`  out  1  one-cycle completion pulse
- `if_rdata`  out  DATA_W  fetched word, valid while `if_ack`=1, held afterwards
- `dm_req`  in  1  data request; held, with all fields stable, until `dm_ack`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_byte`  in  1  byte operation (low 8 bits)
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_ack`  out  1  one-cycle completion pulse
- `dm_rdata`  out  DATA_W  load result, valid while `dm_ack`=1, held afterwards; unchanged by stores
- `mem_address`  out  ADDR_W  to `memory_block.address`
- `mem_write_data`  out  DATA_W  to `write_data`
- `mem_read`, `mem_write`, `mem_byte`  out  1 each  to `memRead`, `memWrite`, `byteOperations`
- `mem_read_data`  in  DATA_W  from `read_data`
- `busy`  out  1  high in states ACCESS and DONE

## Operation
- FSM states:
  - IDLE: if any request is pending, pick the owner, latch its fields into the `mem_*` registers, then go to ACCESS. With no request, stay in IDLE.
  - ACCESS: assert `mem_read` for a load/fetch or `mem_write` for a store, for exactly one cycle. At the end of the cycle, capture `mem_read_data` into the owner's rdata register (loads/fetches only), set the owner's ack, clear `mem_read`/`mem_write`, and go to DONE.
  - DONE: the ack is high. All requests are ignored. Go to IDLE on the next edge.
- Fetch requests drive `mem_byte`=0 and `mem_read`=1.
- A `dm_byte` load returns `memory_block`'s zero-extended byte unchanged. A `dm_byte` store writes only bits [7:0].
- Arbitration happens only in IDLE. Default policy is fixed priority: `dm_req` beats `if_req`.
- Latched address, data and byte bits are held through ACCESS and DONE. Requester changes after grant have no effect.
- Reset values:
  - state=IDLE
  - `if_ack`=`dm_ack`=0
  - `if_rdata`=`dm_rdata`=0
  - all `mem_*` outputs = 0
  - `busy`=0
  - last-grant = data
- Reset mid-transaction aborts it with no ack. A store whose ACCESS cycle had already begun has already written memory; this is accepted.

## Timing
- Request asserted in cycle N while in IDLE:
  - ACCESS in N+1
  - `*_ack` and rdata valid in N+2
  - IDLE in N+3
- Latency is 2 cycles. Throughput is one transaction per 3 cycles.
- The requester must drop or change `req` at the edge ending the ack cycle. If a request is still held in IDLE, it is treated as a new request.
- The losing port waits. Its `req` stays pending and is granted in the next IDLE.
- `mem_read` and `mem_write` are never high simultaneously. Each is high for exactly one cycle per transaction and both are registered outputs.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. When both ports request in IDLE, the port not granted last wins. Last-grant is updated on every grant and resets to data, so the first tie after reset goes to fetch.
- `MEM_ARB_RR_EN` undefined: fixed priority, data over fetch. The last-grant register is not built.

## Test plan
- Reset, then `if_req`=1, `if_addr`=5 with mem[5]=0x00400020 → `mem_read`=1 in N+1 only; `if_ack`=1 in N+2 with `if_rdata`=0x00400020; `dm_ack` stays 0.
- `dm_req`, `dm_we`=1, `dm_byte`=1, `dm_addr`=9, `dm_wdata`=0xDEADBEEF, mem[9]=0x11223344 → mem[9]=0x112233EF after the access. Then a word load of address 9 returns 0x112233EF with `dm_ack`.
- `if_req` and `dm_req` rise in the same cycle, both held → fixed build: data acked at N+2, fetch acked at N+5. RR build after reset: fetch first, then data.
- RR build with both ports continuously re-requesting for 12 cycles → grants alternate fetch/data; neither port gets two consecutive grants.
- `reset` asserted during ACCESS of a load → no ack; all outputs return to 0 at the next edge; FSM is in IDLE; a subsequent request completes normally.
- A store immediately followed by a load to the same address → `mem_write` and `mem_read` are never high together; the load returns the stored value.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory_block signals served by mem_arbiter.
// The arbiter takes the slave view; the core pipeline and memory_block together form the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic              dm_byte;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic              mem_byte;
  logic [DATA_W-1:0] mem_read_data;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  dm_req, dm_we, dm_byte, dm_addr, dm_wdata,
    output dm_ack, dm_rdata,
    output mem_address, mem_write_data, mem_read, mem_write, mem_byte,
    input  mem_read_data,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output dm_req, dm_we, dm_byte, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata,
    input  mem_address, mem_write_data, mem_read, mem_write, mem_byte,
    output mem_read_data,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter and sequencer in front of the single-ported memory_block.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_dm_q, owner_dm_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_byte_q, mem_byte_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_dm;

`ifdef MEM_ARB_RR_EN
  logic              last_dm_q, last_dm_d;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    grant_dm = bus.dm_req && (!bus.if_req || !last_dm_q);
  end
`else
  always_comb begin
    grant_dm = bus.dm_req;
  end
`endif

  always_comb begin
    state_d          = state_q;
    owner_dm_d       = owner_dm_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    mem_byte_d       = mem_byte_q;
    if_ack_d         = 1'b0;
    dm_ack_d         = 1'b0;
    if_rdata_d       = if_rdata_q;
    dm_rdata_d       = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_dm_d        = last_dm_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.dm_req || bus.if_req) begin
          state_d    = S_ACCESS;
          owner_dm_d = grant_dm;
`ifdef MEM_ARB_RR_EN
          last_dm_d  = grant_dm;
`endif
          if (grant_dm) begin
            mem_address_d    = bus.dm_addr;
            mem_write_data_d = bus.dm_wdata;
            mem_byte_d       = bus.dm_byte;
            mem_read_d       = !bus.dm_we;
            mem_write_d      = bus.dm_we;
          end else begin
            mem_address_d    = bus.if_addr;
            mem_write_data_d = '0;
            mem_byte_d       = 1'b0;
            mem_read_d       = 1'b1;
            mem_write_d      = 1'b0;
          end
        end
      end

      S_ACCESS: begin
        // memory_block answers combinationally, so read data is valid by the end of this cycle.
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = S_DONE;
        if (owner_dm_q) begin
          dm_ack_d = 1'b1;
          if (mem_read_q) begin
            dm_rdata_d = bus.mem_read_data;
          end
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = bus.mem_read_data;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      owner_dm_q       <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_byte_q       <= 1'b0;
      if_ack_q         <= 1'b0;
      dm_ack_q         <= 1'b0;
      if_rdata_q       <= '0;
      dm_rdata_q       <= '0;
`ifdef MEM_ARB_RR_EN
      last_dm_q        <= 1'b1;
`endif
    end else begin
      state_q          <= state_d;
      owner_dm_q       <= owner_dm_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_byte_q       <= mem_byte_d;
      if_ack_q         <= if_ack_d;
      dm_ack_q         <= dm_ack_d;
      if_rdata_q       <= if_rdata_d;
      dm_rdata_q       <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_dm_q        <= last_dm_d;
`endif
    end
  end

  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_byte       = mem_byte_q;
  assign bus.if_ack         = if_ack_q;
  assign bus.dm_ack         = dm_ack_q;
  assign bus.if_rdata       = if_rdata_q;
  assign bus.dm_rdata       = dm_rdata_q;
  assign bus.busy           = (state_q != S_IDLE);

endmodule
